// File: rtl/irq_pkg.sv
// rtl/irq_pkg.sv - shared constants, FSM encoding and helpers for the interrupt controller
package irq_pkg;

    // Register offsets relative to the controller's base address
    localparam logic [7:0] MASK_OFF = 8'h00;
    localparam logic [7:0] PEND_OFF = 8'h04;
    localparam logic [7:0] ID_OFF   = 8'h08;
    localparam logic [7:0] EOI_OFF  = 8'h0C;

    // Handshake states seen by the CPU
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_SVC  = 2'd2
    } irq_state_t;

    // Status/ID register bit positions
    localparam int ID_ERR_BIT   = 31;
    localparam int ID_INSVC_BIT = 30;
    localparam int ID_REQ_BIT   = 29;

    // Width of a source ID; never narrower than one bit
    function automatic int id_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/irq_controller_prio_enc.sv
// rtl/irq_controller_prio_enc.sv - circular priority encoder picking the first set bit from a start index
module irq_prio_enc #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] i_elig,
    input  logic [W-1:0] i_start,
    output logic         o_valid,
    output logic [W-1:0] o_idx
);

    // Walk the vector from i_start, wrapping, and report the first eligible index
    always_comb begin
        int idx;
        idx     = 0;
        o_valid = 1'b0;
        o_idx   = '0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(i_start) + k) % N;
            if (!o_valid && i_elig[idx]) begin
                o_valid = 1'b1;
                o_idx   = W'(idx);
            end
        end
    end

endmodule

// File: rtl/irq_controller.sv
// rtl/irq_controller.sv - memory-mapped interrupt controller (optional round robin: IRQ_RR_PRIORITY_EN)
module irq_controller
    import irq_pkg::*;
#(
    parameter int          BITS      = 32,
    parameter int          NUM_SRC   = 4,
    parameter logic [31:0] MASK_ADDR = 32'hF0000100,
    parameter logic [31:0] PEND_ADDR = 32'hF0000104,
    parameter logic [31:0] ID_ADDR   = 32'hF0000108,
    parameter logic [31:0] EOI_ADDR  = 32'hF000010C
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_we,
    input  logic               i_re,
    input  logic [BITS-1:0]    i_mem_addr,
    input  logic [BITS-1:0]    i_data_bus_in,
    input  logic [NUM_SRC-1:0] i_irq_in,
    input  logic               i_intr_ack,
    output logic               o_intr_req,
    output logic [BITS-1:0]    o_data_bus_out
);

    localparam int ID_W = id_width(NUM_SRC);

    logic [NUM_SRC-1:0] r_hist;
    logic [NUM_SRC-1:0] r_mask;
    logic [NUM_SRC-1:0] r_pend;
    logic [ID_W-1:0]    r_cur_id;
    logic               r_in_svc;
    logic               r_eoi_err;
    logic               r_intr_req;
    irq_state_t         r_state;

    logic [NUM_SRC-1:0] w_rise;
    logic               w_mask_wr;
    logic               w_pend_wr;
    logic               w_eoi_wr;
    logic               w_id_rd;
    logic [NUM_SRC-1:0] w_pend_clr_bus;
    logic [NUM_SRC-1:0] w_mask_next;
    logic [NUM_SRC-1:0] w_pend_sw_next;
    logic [NUM_SRC-1:0] w_claim_clr;
    logic [NUM_SRC-1:0] w_eligible;
    logic               w_drop;
    logic               w_claim;
    logic               w_eoi_match;
    logic               w_win_valid;
    logic [ID_W-1:0]    w_win_idx;
    logic [ID_W-1:0]    w_start;
    logic               w_unused_data;

    assign w_rise    = i_irq_in & ~r_hist;
    assign w_mask_wr = i_we && (i_mem_addr == BITS'(MASK_ADDR));
    assign w_pend_wr = i_we && (i_mem_addr == BITS'(PEND_ADDR));
    assign w_eoi_wr  = i_we && (i_mem_addr == BITS'(EOI_ADDR));
    assign w_id_rd   = i_re && !i_we && (i_mem_addr == BITS'(ID_ADDR));

    assign w_pend_clr_bus = w_pend_wr ? i_data_bus_in[NUM_SRC-1:0] : '0;
    assign w_mask_next    = w_mask_wr ? i_data_bus_in[NUM_SRC-1:0] : r_mask;
    // Pending as software leaves it this cycle; a fresh edge beats a clear
    assign w_pend_sw_next = (r_pend & ~w_pend_clr_bus) | w_rise;

    // A request is withdrawn as soon as software disables or clears its source
    assign w_drop  = (r_state == ST_REQ) &&
                     (!w_mask_next[r_cur_id] || !w_pend_sw_next[r_cur_id]);
    assign w_claim = (r_state == ST_REQ) && !w_drop && i_intr_ack;
    assign w_claim_clr = w_claim ? ({{(NUM_SRC-1){1'b0}}, 1'b1} << r_cur_id) : '0;

    assign w_eoi_match = (i_data_bus_in[ID_W-1:0] == r_cur_id);
    assign w_eligible  = r_pend & r_mask;
    assign o_intr_req  = r_intr_req;

    assign w_unused_data = &{1'b0, i_data_bus_in};

`ifdef IRQ_RR_PRIORITY_EN
    logic [ID_W-1:0] r_last_served;
    assign w_start = (r_last_served == ID_W'(NUM_SRC - 1)) ? '0 : r_last_served + 1'b1;
`else
    assign w_start = '0;
`endif

    irq_prio_enc #(
        .N (NUM_SRC),
        .W (ID_W)
    ) u_prio_enc (
        .i_elig  (w_eligible),
        .i_start (w_start),
        .o_valid (w_win_valid),
        .o_idx   (w_win_idx)
    );

    // Edge-detect history of the request lines
    always_ff @(posedge clk) begin
        if (reset) r_hist <= '0;
        else       r_hist <= i_irq_in;
    end

    // Enable mask register
    always_ff @(posedge clk) begin
        if (reset)          r_mask <= '0;
        else if (w_mask_wr) r_mask <= i_data_bus_in[NUM_SRC-1:0];
    end

    // Pending latch: edges set, software write-1 and claims clear, set wins
    always_ff @(posedge clk) begin
        if (reset) r_pend <= '0;
        else       r_pend <= (r_pend & ~w_pend_clr_bus & ~w_claim_clr) | w_rise;
    end

    // Sticky error for an EOI naming the wrong source; reading the ID register clears it
    always_ff @(posedge clk) begin
        if (reset)
            r_eoi_err <= 1'b0;
        else if (w_eoi_wr && (r_state == ST_SVC) && !w_eoi_match)
            r_eoi_err <= 1'b1;
        else if (w_id_rd)
            r_eoi_err <= 1'b0;
    end

    // Request/acknowledge/EOI handshake with registered request output
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_IDLE;
            r_cur_id   <= '0;
            r_in_svc   <= 1'b0;
            r_intr_req <= 1'b0;
`ifdef IRQ_RR_PRIORITY_EN
            r_last_served <= ID_W'(NUM_SRC - 1);
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_intr_req <= 1'b0;
                    if (w_win_valid) begin
                        r_cur_id   <= w_win_idx;
                        r_state    <= ST_REQ;
                        r_intr_req <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (w_drop) begin
                        r_state    <= ST_IDLE;
                        r_intr_req <= 1'b0;
                    end else if (w_claim) begin
                        r_state    <= ST_SVC;
                        r_in_svc   <= 1'b1;
                        r_intr_req <= 1'b0;
`ifdef IRQ_RR_PRIORITY_EN
                        r_last_served <= r_cur_id;
`endif
                    end
                end
                ST_SVC: begin
                    r_intr_req <= 1'b0;
                    if (w_eoi_wr && w_eoi_match) begin
                        r_in_svc <= 1'b0;
                        r_state  <= ST_IDLE;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_intr_req <= 1'b0;
                end
            endcase
        end
    end

    // Combinational register read mux; idle bus reads as zero
    always_comb begin
        o_data_bus_out = '0;
        if (i_re && !i_we) begin
            if (i_mem_addr == BITS'(MASK_ADDR)) begin
                o_data_bus_out = BITS'(r_mask);
            end else if (i_mem_addr == BITS'(PEND_ADDR)) begin
                o_data_bus_out = BITS'(r_pend);
            end else if (i_mem_addr == BITS'(ID_ADDR)) begin
                o_data_bus_out[ID_W-1:0]     = r_cur_id;
                o_data_bus_out[ID_ERR_BIT]   = r_eoi_err;
                o_data_bus_out[ID_INSVC_BIT] = r_in_svc;
                o_data_bus_out[ID_REQ_BIT]   = r_intr_req;
            end
        end
    end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
Memory-mapped interrupt controller that shares the single CPU interrupt line among NUM_SRC peripheral request lines (switch, key, timer ready/IE outputs). It latches source edges into a pending register, arbitrates among enabled pending sources, and runs the request/acknowledge/end-of-interrupt handshake with the CPU. It sits on the same data bus as the peripheral devices and decodes its own register addresses.

Parameters:
BITS, 32, data bus and address width
NUM_SRC, 4, number of interrupt sources (2..32)
MASK_ADDR, 32'hF0000100, enable mask register (R/W, 1 = enabled)
PEND_ADDR, 32'hF0000104, pending register (read; write-1-to-clear)
ID_ADDR, 32'hF0000108, status/ID register (read-only)
EOI_ADDR, 32'hF000010C, end-of-interrupt register (write-only, data = source ID)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
we  in  1  bus write strobe
re  in  1  bus read strobe
memAddr  in  BITS  bus address
dataBusIn  in  BITS  write data
irqIn  in  NUM_SRC  per-source level request from devices
intrAck  in  1  CPU acknowledge, one-cycle pulse
intrReq  out  1  interrupt request to CPU
dataBusOut  out  BITS  read data; 0 when no register address matches or re=0

Behaviour:
- Reset: mask=0, pending=0, curId=0, inService=0, eoiErr=0, state=IDLE, intrReq=0, irqIn edge-detect history=0.
- Pending: bit i set on rising edge of irqIn[i] (registered history, 1-cycle latency). Cleared on claim or on bus write to PEND_ADDR with dataBusIn[i]=1. Set and clear in same cycle: set wins.
- Eligible = pending & mask. Winner = lowest eligible index (fixed priority).
- FSM, one state register:
  IDLE: if eligible != 0, register winner into curId, go REQ. intrReq=0.
  REQ: intrReq=1 (registered output, asserted the cycle after entry). If mask[curId] cleared or pending[curId] cleared by software, drop to IDLE without claim. Else on intrAck=1: clear pending[curId], set inService, go SVC.
  SVC: intrReq=0. Bus write to EOI_ADDR with dataBusIn[ID_W-1:0]==curId -> clear inService, go IDLE. Mismatched EOI write ignored and sets eoiErr (sticky, cleared by reading ID_ADDR).
- intrAck outside REQ is ignored.
- New edges on any source during REQ/SVC only set pending; no preemption.
- Read (re=1, we=0, combinational same cycle): MASK -> {0, mask}; PEND -> {0, pending}; ID_ADDR -> bit 31 = eoiErr, bit 30 = inService, bit 29 = intrReq, [ID_W-1:0] = curId, other bits 0.
- Writes to MASK affect eligibility from the next cycle. Writes to ID_ADDR are ignored.
- ID_W = clog2(NUM_SRC), minimum 1.
- Reset mid-handshake: returns to IDLE with intrReq=0 next edge; claimed source is not restored.

Optional Feature:
IRQ_RR_PRIORITY_EN: when defined, the winner search starts at (lastServed+1) mod NUM_SRC and wraps (round robin); lastServed updates on claim and resets to NUM_SRC-1. When undefined, fixed priority with index 0 highest; no lastServed register.

Decomposition:
- Package irq_pkg: register offset constants, FSM state encoding (IDLE/REQ/SVC), ID register bit positions (ERR=31, INSVC=30, REQ=29), ID_W function.
- Sub-module irq_prio_enc: combinational priority encoder (eligible vector plus start index in, valid plus index out); instantiated once.

Test Plan:
- Reset, then irqIn[2] 0->1, mask=4'b0100 -> pending=4'b0100, intrReq=1 within 3 cycles, ID reads curId=2.
- irqIn[1] and irqIn[3] rise in the same cycle, mask=4'hF -> curId=1. intrAck, EOI=1 -> curId=3 served next (with round robin enabled: after serving 1, pending 0 and 3 -> 3 wins).
- In REQ for source 2, write MASK=0 -> intrReq drops next cycle, state IDLE, pending[2] still 1.
- In SVC for source 2, write EOI=1 -> stays SVC, ID bit31=1. Read ID clears eoiErr. EOI=2 -> IDLE.
- Write PEND=4'b0010 in the same cycle as an irqIn[1] rising edge -> pending[1] stays 1.
- Assert reset during SVC -> next cycle intrReq=0, inService=0, mask=0, all reads 0.
